descriptor_collector: RTL

//  Output side of the descriptor-generator bank. Records which generator each corner was dispatched to,

---
 rtl/orb_pkg.sv | 14 +
 rtl/descriptor_collector_order_fifo.sv | 40 ++++
 rtl/descriptor_collector.sv | 83 ++++++++
 3 files changed

// File: rtl/orb_pkg.sv
// orb_pkg: sizes and shared types for the descriptor-generator bank.
package orb_pkg;
    localparam int NUM_GEN = 4;
    localparam int DESC_W  = 256;
    localparam int COORD_W = 20;
    localparam int ID_W    = $clog2(NUM_GEN);
    localparam int CNT_W   = ID_W + 1;
    typedef logic [ID_W-1:0] gen_id_t;
    typedef struct packed {
        gen_id_t              gen_id;
        logic [COORD_W-1:0]   coord;
    } order_entry_t;
    typedef enum logic {ST_EMPTY, ST_FULL} stage_t;
endpackage

// File: rtl/descriptor_collector_order_fifo.sv
// order_fifo: dispatch-order FIFO of {gen_id, coord}, depth NUM_GEN, combinational head.
module order_fifo
    import orb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  order_entry_t     din,
    output order_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    order_entry_t     mem_q [NUM_GEN];
    gen_id_t          wr_q, rd_q;
    logic [CNT_W-1:0] count_q;

    function automatic gen_id_t nxt(gen_id_t p);
        return p == gen_id_t'(NUM_GEN - 1) ? '0 : p + gen_id_t'(1);
    endfunction

    assign head  = mem_q[rd_q];
    assign full  = count_q == CNT_W'(NUM_GEN);
    assign empty = count_q == '0;
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= nxt(wr_q);
            if (pop) rd_q <= nxt(rd_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
        if (push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/descriptor_collector.sv
// descriptor_collector: returns generator descriptors in dispatch order on a valid/ready stream
// and releases each generator once its descriptor is captured.
module descriptor_collector
    import orb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_GEN-1:0]        dispatch_oh,
    input  logic [COORD_W-1:0]        dispatch_coord,
    input  logic [NUM_GEN-1:0]        desc_done,
    input  logic [NUM_GEN*DESC_W-1:0] desc_data,
    output logic [NUM_GEN-1:0]        gen_release,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DESC_W-1:0]         out_desc,
    output logic [COORD_W-1:0]        out_coord,
    output logic [CNT_W-1:0]          pending,
    output logic                      err
);
    logic [DESC_W-1:0]  descs [NUM_GEN];
    order_entry_t       head, din;
    gen_id_t            disp_id;
    logic               full, empty, one_hot, load, push;
    stage_t             stage_q;
    logic [DESC_W-1:0]  out_desc_q;
    logic [COORD_W-1:0] out_coord_q;
    logic [NUM_GEN-1:0] release_q;
    logic               err_q;

    for (genvar g = 0; g < NUM_GEN; g++) begin : g_slice
        assign descs[g] = desc_data[g*DESC_W +: DESC_W];
    end

    always_comb begin
        disp_id = '0;
        for (int i = 0; i < NUM_GEN; i++)
            if (dispatch_oh[i]) disp_id = gen_id_t'(i);
    end

    assign one_hot = dispatch_oh != '0 && (dispatch_oh & (dispatch_oh - NUM_GEN'(1))) == '0;
    assign load    = !empty && desc_done[head.gen_id] && (stage_q == ST_EMPTY || out_ready);
    // a pop in the same cycle frees a slot, so a full FIFO may still accept the push
    assign push    = one_hot && (!full || load);
    assign din     = '{gen_id: disp_id, coord: dispatch_coord};

    order_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= ST_EMPTY;
            out_desc_q  <= '0;
            out_coord_q <= '0;
            release_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            release_q <= load ? NUM_GEN'(1) << head.gen_id : '0;
            err_q     <= err_q | (dispatch_oh != '0 && !push);
            if (load) begin
                stage_q     <= ST_FULL;
                out_desc_q  <= descs[head.gen_id];
                out_coord_q <= head.coord;
            end else if (out_ready) begin
                stage_q <= ST_EMPTY;
            end
        end
    end

    assign out_valid   = stage_q == ST_FULL;
    assign out_desc    = out_desc_q;
    assign out_coord   = out_coord_q;
    assign gen_release = release_q;
    assign err         = err_q;
endmodule
